// File: rtl/viterbi_channel_model_if.sv
// Symbol stream into and out of the channel model, plus the mask applied to each output symbol.
interface viterbi_channel_model_if #(
    parameter int unsigned W = 2
);
    logic         valid_i;
    logic [W-1:0] sym_i;
    logic         valid_o;
    logic [W-1:0] sym_o;
    logic [W-1:0] err_mask_o;
    logic         err_flag_o;

    modport master (
        output valid_i, sym_i,
        input  valid_o, sym_o, err_mask_o, err_flag_o
    );

    modport slave (
        input  valid_i, sym_i,
        output valid_o, sym_o, err_mask_o, err_flag_o
    );
endinterface

// File: rtl/viterbi_channel_model.sv
// Error-injecting channel between the convolutional encoder and the Viterbi decoder.
// One-cycle latency. Errors are injected only inside a finite window of symbol indices.
module viterbi_channel_model #(
    parameter int unsigned   W         = 2,
    parameter int unsigned   P         = 3,
    parameter int unsigned   N         = 4,
    parameter int unsigned   BURST_LEN = 4,
    parameter int unsigned   WINDOW    = 256,
    parameter logic [W-1:0]  ERR_MASK  = 2'b10,
    parameter logic [15:0]   LFSR_SEED = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic [1:0]             mode_i,
    viterbi_channel_model_if.slave ch,
    output logic [31:0]            sym_ct_o,
    output logic [15:0]            bad_bit_ct_o,
    output logic                   window_done_o
);
    localparam int unsigned LeftW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {StIdle, StBurst} state_e;
    typedef enum logic [1:0] {ModeOff, ModePeriodic, ModeRandom, ModeBurst} mode_e;

    state_e           state_q, state_d, st_nxt;
    logic [LeftW-1:0] left_q, left_d, left_nxt;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [31:0]      sym_ct_q, sym_ct_d;
    logic [15:0]      bad_q, bad_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic [W-1:0]     sym_q, sym_d;
    logic [W-1:0]     mask_q, mask_d;

    logic             in_win, period_hit, lfsr_fb;
    logic [W-1:0]     rnd_cand, mask;
    logic [16:0]      bad_sum;

    // sym_ct_q is the index of the symbol presented this cycle.
    assign in_win     = sym_ct_q < WINDOW;
    assign period_hit = &sym_ct_q[P-1:0];
    assign lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign rnd_cand   = lfsr_q[N+W-1:N];

    // Mask and burst next-state, assuming the current input is a valid symbol.
    always_comb begin
        mask     = '0;
        st_nxt   = StIdle;
        left_nxt = '0;
        if (in_win) begin
            case (mode_e'(mode_i))
                ModePeriodic: begin
                    if (period_hit) mask = ERR_MASK;
                end
                ModeRandom: begin
                    if (lfsr_q[N-1:0] == '0) mask = (rnd_cand == '0) ? ERR_MASK : rnd_cand;
                end
                ModeBurst: begin
                    if (state_q == StBurst) begin
                        mask     = ERR_MASK;
                        left_nxt = left_q - LeftW'(1);
                        st_nxt   = (left_nxt == '0) ? StIdle : StBurst;
                    end else if (period_hit) begin
                        mask = ERR_MASK;
                        if (BURST_LEN > 1) begin
                            st_nxt   = StBurst;
                            left_nxt = LeftW'(BURST_LEN - 1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bad_sum = {1'b0, bad_q} + 17'($countones(mask));

    always_comb begin
        state_d  = state_q;
        left_d   = left_q;
        lfsr_d   = lfsr_q;
        sym_ct_d = sym_ct_q;
        bad_d    = bad_q;
        done_d   = done_q | (sym_ct_q >= WINDOW);
        valid_d  = 1'b0;
        sym_d    = sym_q;
        mask_d   = '0;
        if (clear_i) begin
            state_d  = StIdle;
            left_d   = '0;
            lfsr_d   = LFSR_SEED;
            sym_ct_d = '0;
            bad_d    = '0;
            done_d   = 1'b0;
        end else if (ch.valid_i) begin
            state_d = st_nxt;
            left_d  = left_nxt;
            lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
            valid_d = 1'b1;
            sym_d   = ch.sym_i ^ mask;
            mask_d  = mask;
            if (sym_ct_q != '1) sym_ct_d = sym_ct_q + 32'd1;
            bad_d   = bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            left_q   <= '0;
            lfsr_q   <= LFSR_SEED;
            sym_ct_q <= '0;
            bad_q    <= '0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            sym_q    <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            left_q   <= left_d;
            lfsr_q   <= lfsr_d;
            sym_ct_q <= sym_ct_d;
            bad_q    <= bad_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            sym_q    <= sym_d;
            mask_q   <= mask_d;
        end
    end

    assign ch.valid_o    = valid_q;
    assign ch.sym_o      = sym_q;
    assign ch.err_mask_o = mask_q;
    assign ch.err_flag_o = |mask_q;
    assign sym_ct_o      = sym_ct_q;
    assign bad_bit_ct_o  = bad_q;
    assign window_done_o = done_q;
endmodule
